// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier.
// master = operand source and product sink; slave = the multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     input_1;
    logic [WIDTH-1:0]     input_2;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   output_3;
    logic                 busy;

    modport master (
        output in_valid, input_1, input_2, out_ready,
        input  in_ready, out_valid, output_3, busy
    );

    modport slave (
        input  in_valid, input_1, input_2, out_ready,
        output in_ready, out_valid, output_3, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one operation in flight (SEQ_MULT_EARLY_TERM_EN: early exit).
// Latency: WIDTH CALC cycles after accept (fewer with early exit); product valid the cycle after.
// Backpressure: holds DONE with a stable product until out_ready; in_ready low until then.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     product_q;
    logic [PW-1:0]     acc_step;
    logic              calc_last;
    logic              accept;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.output_3  = product_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        acc_step  = acc_q;
        calc_last = (cnt_q == CW'(WIDTH - 1));
        if (mplier_q[0]) begin
            acc_step = acc_q + mcand_q;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Nothing left to add once the remaining multiplier bits are all zero.
        if (mplier_q[WIDTH-1:1] == '0) begin
            calc_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (calc_last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.input_1};
                        mplier_q <= bus.input_2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (calc_last) begin
                        product_q <= acc_step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier against a plain a*b reference with expected latency.
module tb_seq_multiplier;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected number of CALC cycles for a given multiplier operand.
    function automatic int exp_calc_cycles(input logic [WIDTH-1:0] b);
        int n;
`ifdef SEQ_MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) n = i + 1;
        end
`else
        n = WIDTH;
`endif
        return n;
    endfunction

    // Runs one full operation; expects to start just after a rising edge with the DUT idle.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold,
                         input logic scramble);
        logic [2*WIDTH-1:0] exp_p;
        int cyc;
        exp_p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        bus.in_valid  = 1'b1;
        bus.input_1   = a;
        bus.input_2   = b;
        bus.out_ready = 1'b0;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.input_1 = '1;
            bus.input_2 = '1;
        end
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            check("busy_calc", 32'(bus.busy), 32'd1);
            check("in_ready_calc", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(cyc), 32'(exp_calc_cycles(b)));
        check("product", 32'(bus.output_3), 32'(exp_p));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.input_1  = WIDTH'($urandom);
            bus.input_2  = WIDTH'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_product", 32'(bus.output_3), 32'(exp_p));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("after_valid", 32'(bus.out_valid), 32'd0);
        check("after_busy", 32'(bus.busy), 32'd0);
        check("after_in_ready", 32'(bus.in_ready), 32'd1);
        check("after_product", 32'(bus.output_3), 32'(exp_p));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.input_1   = '0;
        bus.input_2   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_product", 32'(bus.output_3), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        do_op(8'd3, 8'd5, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 0, 1'b0);
        do_op(8'd7, 8'd9, 5, 1'b0);
        do_op(8'h12, 8'h34, 0, 1'b1);
        do_op(8'h40, 8'h00, 0, 1'b0);
        do_op(8'h10, 8'h03, 0, 1'b0);
        do_op(8'h00, 8'hA7, 1, 1'b0);

        // Abort mid-calculation, then confirm a clean restart.
        bus.in_valid = 1'b1;
        bus.input_1  = 8'hAA;
        bus.input_2  = 8'h55;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_product", 32'(bus.output_3), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        @(posedge clk); #1;
        do_op(8'd6, 8'd7, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
